// File: rtl/fp_cvt_sched.sv
// fp_cvt_sched: round-robin scheduler in front of a shared two-stage
// float32 -> int32 truncating converter.
// S1 holds the captured operand and tag. S2 holds the converted result,
// and its registers drive the rsp_* outputs directly.
// Backpressure from rsp_rdy ripples back through the S1/S2 load enables
// to req_rdy.
module fp_cvt_sched #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_vld,
    input  logic [32*NUM_REQ-1:0] req_fp,
    output logic [NUM_REQ-1:0]   req_rdy,
    output logic                 rsp_vld,
    input  logic                 rsp_rdy,
    output logic [ID_W-1:0]      rsp_id,
    output logic [31:0]          rsp_int,
    output logic                 rsp_ovf,
    output logic                 busy
);

    logic [ID_W-1:0]    ptr;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_id;
    logic [31:0]        sel_fp;
    logic               found;
    int                 idx;

    logic               s1_vld;
    logic [31:0]        s1_fp;
    logic [ID_W-1:0]    s1_id;

    logic               s2_vld;
    logic [31:0]        s2_int;
    logic [ID_W-1:0]    s2_id;
    logic               s2_ovf;

    logic               s2_ld;
    logic               s1_ld;
    logic               accept;

    logic [31:0]        cvt_int;
    logic               cvt_ovf;
    logic [23:0]        mant;
    logic [7:0]         exp_unb;
    logic [31:0]        mag;

    // Round-robin search starting just after the last accepted requester.
    always_comb begin
        grant    = '0;
        grant_id = '0;
        sel_fp   = '0;
        found    = 1'b0;
        idx      = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = (int'(ptr) + i) % NUM_REQ;
            if (!found && req_vld[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_id   = ID_W'(idx);
                sel_fp     = req_fp[idx*32 +: 32];
            end
        end
    end

    // Flow control. S2 frees up when empty or being consumed, and S1 frees
    // up when empty or moving into S2. req_rdy is forced low while reset is
    // asserted so that every output shows its reset value.
    always_comb begin
        s2_ld   = !s2_vld || rsp_rdy;
        s1_ld   = !s1_vld || s2_ld;
        req_rdy = (rst_n && s1_ld) ? grant : '0;
        accept  = |req_rdy;
    end

    // Truncating float32 -> int32 conversion of the S1 operand.
    always_comb begin
        cvt_int = '0;
        cvt_ovf = 1'b0;
        mant    = {1'b1, s1_fp[22:0]};
        exp_unb = '0;
        mag     = '0;
        if (s1_fp[30:23] < 8'd127) begin
            cvt_int = '0;
        end else if (s1_fp[30:23] <= 8'd157) begin
            exp_unb = s1_fp[30:23] - 8'd127;
            if (exp_unb <= 8'd23)
                mag = {8'b0, mant} >> (8'd23 - exp_unb);
            else
                mag = {8'b0, mant} << (exp_unb - 8'd23);
            cvt_int = s1_fp[31] ? (~mag + 32'd1) : mag;
        end else if (s1_fp[31] && s1_fp[30:23] == 8'd158 && s1_fp[22:0] == 23'd0) begin
            // -2^31 is exactly representable, so it is not an overflow.
            cvt_int = 32'h8000_0000;
        end else begin
            cvt_int = s1_fp[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
            cvt_ovf = 1'b1;
        end
    end

    // Priority pointer: moves to the winner only when its operand is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= ID_W'(NUM_REQ - 1);
        end else if (accept) begin
            ptr <= grant_id;
        end
    end

    // Stage 1: capture the granted operand and its tag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld <= 1'b0;
            s1_fp  <= '0;
            s1_id  <= '0;
        end else if (s1_ld) begin
            s1_vld <= accept;
            if (accept) begin
                s1_fp <= sel_fp;
                s1_id <= grant_id;
            end
        end
    end

    // Stage 2: register the conversion result. It holds steady while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_vld <= 1'b0;
            s2_int <= '0;
            s2_id  <= '0;
            s2_ovf <= 1'b0;
        end else if (s2_ld) begin
            s2_vld <= s1_vld;
            if (s1_vld) begin
                s2_int <= cvt_int;
                s2_id  <= s1_id;
                s2_ovf <= cvt_ovf;
            end
        end
    end

    // Outputs come straight from stage 2.
    always_comb begin
        rsp_vld = s2_vld;
        rsp_int = s2_int;
        rsp_id  = s2_id;
        rsp_ovf = s2_ovf;
        busy    = s1_vld || s2_vld;
    end

endmodule

// File: tb/tb_fp_cvt_sched.sv
// Self-checking bench for fp_cvt_sched (NUM_REQ = 4).
module tb_fp_cvt_sched;

    localparam int N = 4;

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    req_vld;
    logic [32*N-1:0] req_fp;
    logic [N-1:0]    req_rdy;
    logic            rsp_vld;
    logic            rsp_rdy;
    logic [1:0]      rsp_id;
    logic [31:0]     rsp_int;
    logic            rsp_ovf;
    logic            busy;

    fp_cvt_sched #(.NUM_REQ(N)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req_vld (req_vld),
        .req_fp  (req_fp),
        .req_rdy (req_rdy),
        .rsp_vld (rsp_vld),
        .rsp_rdy (rsp_rdy),
        .rsp_id  (rsp_id),
        .rsp_int (rsp_int),
        .rsp_ovf (rsp_ovf),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] fp;
        logic [31:0] res;
        logic        ovf;
    } vec_t;

    typedef struct {
        logic       rdy;
        logic       vld;
        logic [3:0] rr;
        logic       rv;
        logic [1:0] id;
    } cyc_t;

    vec_t vecs[14];
    cyc_t seq[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        req_vld = '0;
        rsp_rdy = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Each row is one cycle. Inputs are driven at the falling edge, and the
    // outputs are checked 1 ns later. All four requesters present values
    // 1.0 to 4.0, so a result is always its id+1.
    task automatic run_seq(input string nm);
        foreach (seq[c]) begin
            @(negedge clk);
            rsp_rdy = seq[c].rdy;
            req_vld = seq[c].vld ? 4'hF : 4'h0;
            #1;
            chk({nm, " req_rdy"}, 32'(req_rdy), 32'(seq[c].rr));
            chk({nm, " rsp_vld"}, 32'(rsp_vld), 32'(seq[c].rv));
            if (seq[c].rv) begin
                chk({nm, " rsp_id"},  32'(rsp_id), 32'(seq[c].id));
                chk({nm, " rsp_int"}, rsp_int, 32'(seq[c].id) + 32'd1);
                chk({nm, " rsp_ovf"}, 32'(rsp_ovf), 32'd0);
            end
        end
        seq.delete();
    endtask

    function automatic cyc_t cy(logic r, logic v, logic [3:0] rr, logic rv, logic [1:0] id);
        cyc_t t;
        t.rdy = r; t.vld = v; t.rr = rr; t.rv = rv; t.id = id;
        return t;
    endfunction

    initial begin
        vecs[0]  = '{32'h40490FDB, 32'h00000003, 1'b0};
        vecs[1]  = '{32'hC0200000, 32'hFFFFFFFE, 1'b0};
        vecs[2]  = '{32'h3F000000, 32'h00000000, 1'b0};
        vecs[3]  = '{32'h80000000, 32'h00000000, 1'b0};
        vecs[4]  = '{32'h3F800000, 32'h00000001, 1'b0};
        vecs[5]  = '{32'h4F000000, 32'h7FFFFFFF, 1'b1};
        vecs[6]  = '{32'hCF000000, 32'h80000000, 1'b0};
        vecs[7]  = '{32'hFF800000, 32'h80000000, 1'b1};
        vecs[8]  = '{32'h7FC00000, 32'h7FFFFFFF, 1'b1};
        vecs[9]  = '{32'h4EFFFFFF, 32'h7FFFFF80, 1'b0};
        vecs[10] = '{32'h4B000001, 32'h00800001, 1'b0};
        vecs[11] = '{32'h4B800001, 32'h01000002, 1'b0};
        vecs[12] = '{32'h00000001, 32'h00000000, 1'b0};
        vecs[13] = '{32'hC2F60000, 32'hFFFFFF85, 1'b0};

        rst_n   = 1'b0;
        req_vld = '0;
        req_fp  = '0;
        rsp_rdy = 1'b0;
        #1;
        chk("reset rsp_vld", 32'(rsp_vld), 32'd0);
        chk("reset busy",    32'(busy),    32'd0);
        chk("reset rsp_int", rsp_int,      32'd0);
        chk("reset rsp_id",  32'(rsp_id),  32'd0);
        chk("reset rsp_ovf", 32'(rsp_ovf), 32'd0);
        chk("reset req_rdy", 32'(req_rdy), 32'd0);
        do_reset();

        // Single operands, rotated across the requesters. Each one is accepted
        // at edge k, is absent after edge k, is present after edge k+1, and is
        // consumed at edge k+2.
        foreach (vecs[i]) begin
            int r;
            r = i % N;
            @(negedge clk);
            rsp_rdy = 1'b1;
            req_fp  = '0;
            req_fp[32*r +: 32] = vecs[i].fp;
            req_vld = 4'(1 << r);
            #1;
            chk("vec req_rdy", 32'(req_rdy), 32'(1 << r));
            @(negedge clk);
            req_vld = '0;
            #1;
            chk("vec early rsp_vld", 32'(rsp_vld), 32'd0);
            chk("vec busy", 32'(busy), 32'd1);
            @(negedge clk);
            chk("vec rsp_vld", 32'(rsp_vld), 32'd1);
            chk("vec rsp_int", rsp_int, vecs[i].res);
            chk("vec rsp_ovf", 32'(rsp_ovf), 32'(vecs[i].ovf));
            chk("vec rsp_id",  32'(rsp_id), 32'(r));
            @(negedge clk);
            chk("vec drained", 32'(rsp_vld), 32'd0);
        end

        req_fp = {32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000};

        // Fairness: with all four requesters pending, grants go 0,1,2,3,0,1
        // and the results come back one per cycle.
        do_reset();
        seq.push_back(cy(1, 1, 4'b0001, 0, 0));
        seq.push_back(cy(1, 1, 4'b0010, 0, 0));
        seq.push_back(cy(1, 1, 4'b0100, 1, 0));
        seq.push_back(cy(1, 1, 4'b1000, 1, 1));
        seq.push_back(cy(1, 1, 4'b0001, 1, 2));
        seq.push_back(cy(1, 1, 4'b0010, 1, 3));
        seq.push_back(cy(1, 0, 4'b0000, 1, 0));
        seq.push_back(cy(1, 0, 4'b0000, 1, 1));
        seq.push_back(cy(1, 0, 4'b0000, 0, 0));
        run_seq("fair");

        // Backpressure: rsp_rdy is held low for 3 cycles. Result 0 stays frozen,
        // req_rdy stays 0, and after that 0,1,2,3 each appear exactly once.
        do_reset();
        seq.push_back(cy(1, 1, 4'b0001, 0, 0));
        seq.push_back(cy(1, 1, 4'b0010, 0, 0));
        seq.push_back(cy(0, 1, 4'b0000, 1, 0));
        seq.push_back(cy(0, 1, 4'b0000, 1, 0));
        seq.push_back(cy(0, 1, 4'b0000, 1, 0));
        seq.push_back(cy(1, 1, 4'b0100, 1, 0));
        seq.push_back(cy(1, 1, 4'b1000, 1, 1));
        seq.push_back(cy(1, 0, 4'b0000, 1, 2));
        seq.push_back(cy(1, 0, 4'b0000, 1, 3));
        seq.push_back(cy(1, 0, 4'b0000, 0, 0));
        run_seq("bp");
        chk("bp busy end", 32'(busy), 32'd0);

        // Reset while both stages are full.
        do_reset();
        @(negedge clk);
        rsp_rdy = 1'b0;
        req_vld = 4'hF;
        repeat (2) @(negedge clk);
        #1;
        chk("rst pre busy", 32'(busy), 32'd1);
        chk("rst pre rsp_vld", 32'(rsp_vld), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst rsp_vld", 32'(rsp_vld), 32'd0);
        chk("rst busy",    32'(busy),    32'd0);
        chk("rst rsp_int", rsp_int,      32'd0);
        chk("rst req_rdy", 32'(req_rdy), 32'd0);
        @(negedge clk);
        req_vld = 4'b0101;
        rsp_rdy = 1'b1;
        rst_n   = 1'b1;
        #1;
        chk("rst first grant", 32'(req_rdy), 32'b0001);
        chk("rst no stale rsp", 32'(rsp_vld), 32'd0);
        @(negedge clk);
        req_vld = '0;
        #1;
        chk("rst rsp_vld k+1", 32'(rsp_vld), 32'd0);
        @(negedge clk);
        chk("rst rsp_vld k+2", 32'(rsp_vld), 32'd1);
        chk("rst rsp_id",      32'(rsp_id),  32'd0);
        chk("rst rsp_int val", rsp_int,      32'd1);
        @(negedge clk);
        chk("rst drained", 32'(rsp_vld), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
